// File: rtl/skolem_chk_pkg.sv
// Shared constants and FSM state type for the Skolem certificate checker.
package skolem_chk_pkg;

    localparam int W          = 4;
    localparam int NUM_PAIRS  = 256;
    localparam int FAIL_CNT_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        EVAL,
        SWEEP,
        FINISH
    } state_t;

endpackage

// File: rtl/bvugt_shl_eval.sv
// Combinational predicate: sat = ((x << s) mod 2^W) >u t.
module bvugt_shl_eval #(
    parameter int W = skolem_chk_pkg::W
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] s,
    input  logic [W-1:0] t,
    output logic         sat
);

    logic [W-1:0] shifted;

    // A W-bit shift by W or more pushes every bit out, giving 0 as intended.
    assign shifted = x << s;
    assign sat     = (shifted > t);

endmodule

// File: rtl/skolem_cert_checker.sv
// Walks all (s,t) pairs through an external Skolem netlist and counts pairs whose
// returned candidate is wrong although a satisfying x exists.
module skolem_cert_checker #(
    parameter int W = skolem_chk_pkg::W
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    output logic [W-1:0]                        s_o,
    output logic [W-1:0]                        t_o,
    input  logic [W-1:0]                        x_i,
    output logic                                busy,
    output logic                                done,
    output logic                                pass,
    output logic [skolem_chk_pkg::FAIL_CNT_W-1:0] fail_count,
    output logic [W-1:0]                        ff_s,
    output logic [W-1:0]                        ff_t,
    output logic [W-1:0]                        ff_x,
    output logic                                ff_valid
);
    import skolem_chk_pkg::*;

    state_t         state;
    state_t         state_nx;
    logic [2*W-1:0] idx;
    logic [W-1:0]   sweep_x;
    logic [W-1:0]   cand_x;
    logic           res_valid;
    logic           cand_sat;
    logic           sweep_sat;
    logic           last_pair;
    logic           do_start;
    logic           do_advance;
    logic           do_record;

    assign s_o       = idx[2*W-1:W];
    assign t_o       = idx[W-1:0];
    assign last_pair = (idx == '1);

    bvugt_shl_eval #(.W(W)) u_cand_eval (
        .x   (x_i),
        .s   (s_o),
        .t   (t_o),
        .sat (cand_sat)
    );

    bvugt_shl_eval #(.W(W)) u_sweep_eval (
        .x   (sweep_x),
        .s   (s_o),
        .t   (t_o),
        .sat (sweep_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A witness found by the sweep means the candidate was wrong for an invertible pair.
    always_comb begin
        state_nx   = state;
        do_start   = 1'b0;
        do_advance = 1'b0;
        do_record  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    do_start = 1'b1;
                    state_nx = APPLY;
                end
            end
            APPLY:  state_nx = EVAL;
            EVAL: begin
                if (cand_sat) begin
                    do_advance = 1'b1;
                end else begin
                    state_nx = SWEEP;
                end
            end
            SWEEP: begin
                if (sweep_sat) begin
                    do_record  = 1'b1;
                    do_advance = 1'b1;
                end else if (sweep_x == '1) begin
                    do_advance = 1'b1;
                end
            end
            FINISH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (do_advance) begin
            state_nx = last_pair ? FINISH : APPLY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            sweep_x    <= '0;
            cand_x     <= '0;
            res_valid  <= 1'b0;
            fail_count <= '0;
            ff_s       <= '0;
            ff_t       <= '0;
            ff_x       <= '0;
            ff_valid   <= 1'b0;
        end else begin
            if (do_start) begin
                idx        <= '0;
                res_valid  <= 1'b0;
                fail_count <= '0;
                ff_s       <= '0;
                ff_t       <= '0;
                ff_x       <= '0;
                ff_valid   <= 1'b0;
            end
            if (state == EVAL) begin
                cand_x  <= x_i;
                sweep_x <= '0;
            end
            if ((state == SWEEP) && !do_advance) begin
                sweep_x <= sweep_x + 1'b1;
            end
            if (do_record) begin
                if (fail_count != FAIL_CNT_W'(NUM_PAIRS)) begin
                    fail_count <= fail_count + 1'b1;
                end
                if (!ff_valid) begin
                    ff_s     <= s_o;
                    ff_t     <= t_o;
                    ff_x     <= cand_x;
                    ff_valid <= 1'b1;
                end
            end
            if (do_advance && !last_pair) begin
                idx <= idx + 1'b1;
            end
            if (state == FINISH) begin
                res_valid <= 1'b1;
            end
        end
    end

    assign busy = (state == APPLY) || (state == EVAL) || (state == SWEEP);
    assign done = (state == FINISH);
    assign pass = (res_valid || done) && (fail_count == '0);

endmodule

// File: tb/tb_skolem_cert_checker.sv
// Bench for skolem_cert_checker: models the external Skolem netlist in several
// fault modes and scoreboards the sweep result against a reference model.
module tb_skolem_cert_checker;

    localparam int MODE_OK      = 0;
    localparam int MODE_STUCK0  = 1;
    localparam int MODE_FAULT37 = 2;

    typedef struct {
        int fails;
        bit pass;
        bit ffv;
        int ffs;
        int fft;
        int ffx;
        int cycles;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] s_o;
    logic [3:0] t_o;
    logic [3:0] x_i;
    logic       busy;
    logic       done;
    logic       pass;
    logic [8:0] fail_count;
    logic [3:0] ff_s;
    logic [3:0] ff_t;
    logic [3:0] ff_x;
    logic       ff_valid;

    int   mode = MODE_OK;
    int   n_checks = 0;
    int   n_fail = 0;
    int   pair_cycles [256];
    exp_t sb [$];

    skolem_cert_checker #(.W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .s_o        (s_o),
        .t_o        (t_o),
        .x_i        (x_i),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_count (fail_count),
        .ff_s       (ff_s),
        .ff_t       (ff_t),
        .ff_x       (ff_x),
        .ff_valid   (ff_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference predicate written with multiplication rather than a shift.
    function automatic bit p_ref(input int x, input int s, input int t);
        if (s >= 4) return 1'b0;
        return ((x * (1 << s)) % 16) > t;
    endfunction

    // Skolem netlist stand-in: smallest witness when one exists, a scrambled value otherwise.
    function automatic logic [3:0] skolem_net(input logic [3:0] s, input logic [3:0] t, input int m);
        logic [3:0] x;
        if (m == MODE_STUCK0) return 4'd0;
        if (m == MODE_FAULT37 && s == 4'd3 && t == 4'd7) return 4'd0;
        x = 4'((int'(s) * 7 + int'(t) * 3) % 16);
        for (int k = 15; k >= 0; k--) begin
            if (p_ref(k, int'(s), int'(t))) x = 4'(k);
        end
        return x;
    endfunction

    always_comb x_i = skolem_net(s_o, t_o, mode);

    function automatic exp_t model(input int m);
        exp_t       e;
        int         s;
        int         t;
        int         k;
        logic [3:0] c;
        e = '{default: 0};
        for (int idx = 0; idx < 256; idx++) begin
            s = idx / 16;
            t = idx % 16;
            c = skolem_net(4'(s), 4'(t), m);
            if (p_ref(int'(c), s, t)) begin
                e.cycles += 2;
            end else begin
                k = 0;
                while (k < 16 && !p_ref(k, s, t)) k++;
                if (k == 16) begin
                    e.cycles += 18;
                end else begin
                    e.cycles += 3 + k;
                    if (e.fails == 0) begin
                        e.ffs = s;
                        e.fft = t;
                        e.ffx = int'(c);
                        e.ffv = 1'b1;
                    end
                    e.fails++;
                end
            end
        end
        e.pass = (e.fails == 0);
        return e;
    endfunction

    task automatic launch(input int m);
        mode = m;
        sb.push_back(model(m));
        for (int i = 0; i < 256; i++) pair_cycles[i] = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int poke_at, output int cyc, output bit timeout);
        cyc = 0;
        timeout = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            start = (i == poke_at);
            if (done === 1'b1) begin
                timeout = 1'b0;
                break;
            end
            if (busy === 1'b1) begin
                cyc++;
                pair_cycles[{s_o, t_o}]++;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({s_o, t_o, busy, done, pass, fail_count, ff_s, ff_t, ff_x, ff_valid} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset.outputs: got %h, expected 0",
                     {s_o, t_o, busy, done, pass, fail_count, ff_s, ff_t, ff_x, ff_valid});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_correct_sweep();
        exp_t e;
        int   cyc;
        bit   to;
        launch(MODE_OK);
        wait_done(-1, cyc, to);
        e = sb.pop_front();
        n_checks++;
        if (to) begin n_fail++; $display("[TB] FAIL ok.timeout: done never seen"); end
        n_checks++;
        if (cyc != e.cycles) begin n_fail++; $display("[TB] FAIL ok.busy_cycles: got %0d, expected %0d", cyc, e.cycles); end
        n_checks++;
        if (fail_count !== 9'(e.fails)) begin n_fail++; $display("[TB] FAIL ok.fail_count: got %0d, expected %0d", fail_count, e.fails); end
        n_checks++;
        if (pass !== e.pass) begin n_fail++; $display("[TB] FAIL ok.pass: got %b, expected %b", pass, e.pass); end
        n_checks++;
        if (ff_valid !== e.ffv) begin n_fail++; $display("[TB] FAIL ok.ff_valid: got %b, expected %b", ff_valid, e.ffv); end
        n_checks++;
        if (pair_cycles[8'h50] != 18) begin n_fail++; $display("[TB] FAIL ok.pair_5_0_cycles: got %0d, expected 18", pair_cycles[8'h50]); end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL ok.done_pulse: done=%b busy=%b, expected 0 0", done, busy); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (pass !== e.pass || s_o !== 4'hF || t_o !== 4'hF || fail_count !== 9'(e.fails)) begin
            n_fail++;
            $display("[TB] FAIL ok.idle_hold: pass=%b s=%0d t=%0d fc=%0d, expected %b 15 15 %0d",
                     pass, s_o, t_o, fail_count, e.pass, e.fails);
        end
    endtask

    task automatic test_stuck_zero();
        exp_t e;
        int   cyc;
        bit   to;
        launch(MODE_STUCK0);
        wait_done(-1, cyc, to);
        e = sb.pop_front();
        n_checks++;
        if (to) begin n_fail++; $display("[TB] FAIL stuck0.timeout: done never seen"); end
        n_checks++;
        if (fail_count !== 9'(e.fails)) begin n_fail++; $display("[TB] FAIL stuck0.fail_count: got %0d, expected %0d", fail_count, e.fails); end
        n_checks++;
        if ({ff_valid, ff_s, ff_t, ff_x} !== {e.ffv, 4'(e.ffs), 4'(e.fft), 4'(e.ffx)}) begin
            n_fail++;
            $display("[TB] FAIL stuck0.first_fail: got v=%b s=%0d t=%0d x=%0d, expected v=%b s=%0d t=%0d x=%0d",
                     ff_valid, ff_s, ff_t, ff_x, e.ffv, e.ffs, e.fft, e.ffx);
        end
        n_checks++;
        if (pass !== e.pass) begin n_fail++; $display("[TB] FAIL stuck0.pass: got %b, expected %b", pass, e.pass); end
        n_checks++;
        if (cyc != e.cycles) begin n_fail++; $display("[TB] FAIL stuck0.busy_cycles: got %0d, expected %0d", cyc, e.cycles); end
        @(negedge clk);
    endtask

    task automatic test_single_fault();
        exp_t e;
        int   cyc;
        bit   to;
        launch(MODE_FAULT37);
        wait_done(-1, cyc, to);
        e = sb.pop_front();
        n_checks++;
        if (to) begin n_fail++; $display("[TB] FAIL fault37.timeout: done never seen"); end
        n_checks++;
        if (fail_count !== 9'(e.fails)) begin n_fail++; $display("[TB] FAIL fault37.fail_count: got %0d, expected %0d", fail_count, e.fails); end
        n_checks++;
        if ({ff_valid, ff_s, ff_t, ff_x} !== {e.ffv, 4'(e.ffs), 4'(e.fft), 4'(e.ffx)}) begin
            n_fail++;
            $display("[TB] FAIL fault37.first_fail: got v=%b s=%0d t=%0d x=%0d, expected v=%b s=%0d t=%0d x=%0d",
                     ff_valid, ff_s, ff_t, ff_x, e.ffv, e.ffs, e.fft, e.ffx);
        end
        n_checks++;
        if (pair_cycles[8'h37] != 4) begin n_fail++; $display("[TB] FAIL fault37.pair_3_7_cycles: got %0d, expected 4", pair_cycles[8'h37]); end
        n_checks++;
        if (cyc != e.cycles) begin n_fail++; $display("[TB] FAIL fault37.busy_cycles: got %0d, expected %0d", cyc, e.cycles); end
        n_checks++;
        if (pass !== e.pass) begin n_fail++; $display("[TB] FAIL fault37.pass: got %b, expected %b", pass, e.pass); end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        exp_t e;
        int   cyc;
        bit   to;
        launch(MODE_OK);
        wait_done(100, cyc, to);
        e = sb.pop_front();
        n_checks++;
        if (to) begin n_fail++; $display("[TB] FAIL restart.timeout: done never seen"); end
        n_checks++;
        if (cyc != e.cycles) begin n_fail++; $display("[TB] FAIL restart.busy_cycles: got %0d, expected %0d", cyc, e.cycles); end
        n_checks++;
        if (fail_count !== 9'(e.fails) || pass !== e.pass || ff_valid !== e.ffv) begin
            n_fail++;
            $display("[TB] FAIL restart.result: got fc=%0d pass=%b ffv=%b, expected %0d %b %b",
                     fail_count, pass, ff_valid, e.fails, e.pass, e.ffv);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_sweep();
        exp_t e;
        int   cyc;
        bit   to;
        bit   found;
        mode = MODE_STUCK0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (busy === 1'b1 && s_o == 4'd0 && t_o == 4'd15) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!found) begin n_fail++; $display("[TB] FAIL midreset.reach_pair: pair (0,15) never applied"); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || fail_count !== 9'd15 || ff_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midreset.pre_state: got busy=%b fc=%0d ffv=%b, expected 1 15 1", busy, fail_count, ff_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({s_o, t_o, busy, done, pass, fail_count, ff_s, ff_t, ff_x, ff_valid} !== '0) begin
            n_fail++;
            $display("[TB] FAIL midreset.outputs: got %h, expected 0",
                     {s_o, t_o, busy, done, pass, fail_count, ff_s, ff_t, ff_x, ff_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset.stays_idle: busy=%b done=%b, expected 0 0", busy, done); end
        launch(MODE_OK);
        wait_done(-1, cyc, to);
        e = sb.pop_front();
        n_checks++;
        if (to || cyc != e.cycles) begin n_fail++; $display("[TB] FAIL midreset.rerun_cycles: got %0d (timeout=%b), expected %0d", cyc, to, e.cycles); end
        n_checks++;
        if (fail_count !== 9'(e.fails) || pass !== e.pass || ff_valid !== e.ffv) begin
            n_fail++;
            $display("[TB] FAIL midreset.rerun_result: got fc=%0d pass=%b ffv=%b, expected %0d %b %b",
                     fail_count, pass, ff_valid, e.fails, e.pass, e.ffv);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        bit   to;
        launch(MODE_STUCK0);
        wait_done(-1, cyc, to);
        e = sb.pop_front();
        n_checks++;
        if (to || fail_count !== 9'(e.fails)) begin n_fail++; $display("[TB] FAIL b2b.first_fc: got %0d (timeout=%b), expected %0d", fail_count, to, e.fails); end
        @(negedge clk);
        launch(MODE_OK);
        n_checks++;
        if (fail_count !== 9'd0 || ff_valid !== 1'b0 || pass !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b.cleared_on_start: got fc=%0d ffv=%b pass=%b, expected 0 0 0", fail_count, ff_valid, pass);
        end
        wait_done(-1, cyc, to);
        e = sb.pop_front();
        n_checks++;
        if (to || cyc != e.cycles) begin n_fail++; $display("[TB] FAIL b2b.second_cycles: got %0d (timeout=%b), expected %0d", cyc, to, e.cycles); end
        n_checks++;
        if (fail_count !== 9'(e.fails) || pass !== e.pass || ff_valid !== e.ffv) begin
            n_fail++;
            $display("[TB] FAIL b2b.second_result: got fc=%0d pass=%b ffv=%b, expected %0d %b %b",
                     fail_count, pass, ff_valid, e.fails, e.pass, e.ffv);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_correct_sweep();
        test_stuck_zero();
        test_single_fault();
        test_start_ignored();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/skolem_cert_checker.md
SKOLEM_CERT_CHECKER -- requirements
Module: skolem_cert_checker

Interface
REQ-001 SHALL have parameter W, default 4, giving the bit-width of s, t and x; only W=4 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin a full sweep.
REQ-005 SHALL have port s_o, output, W, the shift operand driven to the Skolem netlist (i0..i3, i0 LSB).
REQ-006 SHALL have port t_o, output, W, the bound operand driven to the Skolem netlist (i4..i7, i4 LSB).
REQ-007 SHALL have port x_i, input, W, the candidate returned by the Skolem netlist (i8..i11, i8 LSB); it is combinational from s_o/t_o.
REQ-008 SHALL have port busy, output, 1, high while a sweep is in progress.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse at sweep end.
REQ-010 SHALL have port pass, output, 1, valid from done until the next start; high iff fail_count==0.
REQ-011 SHALL have port fail_count, output, 9, the number of invertible pairs with a wrong candidate.
REQ-012 SHALL have ports ff_s, ff_t and ff_x, output, W each, holding s, t and x of the first failure.
REQ-013 SHALL have port ff_valid, output, 1, high once the first-failure fields are loaded.

Function
REQ-014 SHALL define the predicate P(x,s,t) = ((x << s) mod 2^W) >u t, with shift amounts >= W yielding 0.
REQ-015 SHALL call a pair (s,t) invertible iff some x in 0..15 satisfies P.
REQ-016 SHALL visit all 256 pairs in ascending index {s,t}, with t the LSBs, so t increments first.
REQ-017 SHALL implement an FSM with states IDLE, APPLY, EVAL, SWEEP and FINISH.
REQ-018 SHALL, in IDLE with start=1, clear fail_count, ff_* and pass, set index to 0, go to APPLY and assert busy from the next cycle.
REQ-019 SHALL, in APPLY, hold s_o/t_o at the index for one cycle, then go to EVAL.
REQ-020 SHALL, in EVAL, sample x_i and evaluate P(x_i,s,t); on true, advance the pair; on false, go to SWEEP with the sweep counter at 0.
REQ-021 SHALL, in SWEEP, test one x per cycle (0..15) against P internally, leaving s_o/t_o unchanged.
REQ-022 SHALL, on the first satisfying x, stop the sweep, increment fail_count, load ff_* on the first failure only, then advance.
REQ-023 SHALL, when x=15 fails in SWEEP, treat the pair as non-invertible, record nothing, and advance.
REQ-024 SHALL, on advance, go to APPLY with index+1, or to FINISH after index 255.
REQ-025 SHALL, in FINISH, pulse done for one cycle, drop busy, drive pass, and return to IDLE.
REQ-026 SHALL ignore start while busy.
REQ-027 SHALL hold outputs stable in IDLE.
REQ-028 SHALL saturate fail_count at 256, which is unreachable in practice.
REQ-029 SHALL take 2 cycles per passing pair, and 2+k cycles when the sweep ends at x=k-1.

Reset
REQ-030 SHALL, on rst_n low at any time including mid-sweep, go to IDLE immediately.
REQ-031 SHALL, on reset, zero all outputs: s_o, t_o, busy, done, pass, fail_count, ff_* and ff_valid.
REQ-032 SHALL abandon any sweep interrupted by reset; a new start is required.

Structure
REQ-033 SHALL place W, the state enum, and the pair-count constant 256 in the shared package skolem_chk_pkg.
REQ-034 SHALL put P in one combinational sub-module, bvugt_shl_eval (ports x, s, t, sat), instantiated twice: once for the candidate and once for the sweep.
REQ-035 SHALL keep the Skolem netlist outside this block; the bench connects it to s_o/t_o/x_i.

Verification
REQ-036 SHALL cover: correct Skolem netlist -> done after exactly 3824 busy cycles (207 non-invertible pairs sweep 16), pass=1, fail_count=0, ff_valid=0.
REQ-037 SHALL cover: x_i stuck at 0 -> fail_count=49, ff_s=0, ff_t=0, ff_x=0, pass=0.
REQ-038 SHALL cover: x_i forced to 0 only at s=3,t=7 (correct elsewhere) -> fail_count=1, ff_s=3, ff_t=7, ff_x=0; that pair costs 2+2 cycles because the witness x=1 is found on the second sweep step.
REQ-039 SHALL cover: start asserted again at cycle 100 of a sweep -> ignored, and the result is identical to the first scenario.
REQ-040 SHALL cover: rst_n pulsed low mid-SWEEP -> all outputs 0 within the same cycle, IDLE; a new start then gives the full first-scenario result.
REQ-041 SHALL cover: non-invertible pair s=5,t=0 with any x_i -> no count change; the sweep takes 16 cycles.
